// File: rtl/wb_irq_mux_pkg.sv
// rtl/wb_irq_mux_pkg.sv - register map, bus states and configuration checks for wb_irq_mux
package wb_irq_mux_pkg;

  localparam int IRQ_VEC_W       = 32;
  localparam int IRQ_NUM_SRC_MAX = 30;
  localparam int IRQ_BASE_MIN    = 2;  // bits 0/1 stay free for non-maskable sources

  // Byte offsets; bits [4:2] select the register.
  localparam logic [4:0] IRQ_REG_STATUS   = 5'h00;
  localparam logic [4:0] IRQ_REG_PENDING  = 5'h04;
  localparam logic [4:0] IRQ_REG_MASK     = 5'h08;
  localparam logic [4:0] IRQ_REG_MODE     = 5'h0C;
  localparam logic [4:0] IRQ_REG_POLARITY = 5'h10;
  localparam logic [4:0] IRQ_REG_SWSET    = 5'h14;

  localparam logic [31:0] IRQ_RST_DATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ACK,
    BUS_ERR
  } bus_state_e;

  function automatic bit irq_cfg_ok(input int num_src, input int irq_base, input int sync_stages);
    return (num_src >= 1) && (num_src <= IRQ_NUM_SRC_MAX) &&
           (irq_base >= IRQ_BASE_MIN) && (irq_base + num_src <= IRQ_VEC_W) &&
           (sync_stages >= 2) && (sync_stages <= 3);
  endfunction

endpackage

// File: rtl/wb_irq_sync.sv
// rtl/wb_irq_sync.sv - per-source synchronizer, polarity correction and rising-edge detect
//   clk, rst_n : clock, asynchronous active-low reset
//   src        : asynchronous raw interrupt input
//   pol        : 1 = active-high/rising, 0 = active-low/falling
//   act        : synchronized, polarity-corrected active level
//   rise       : act went 0->1 since the previous cycle
module wb_irq_sync
  import wb_irq_mux_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic pol,
  output logic act,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= IRQ_RST_DATA[0];
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
      // Tracks the corrected level, so a polarity flip alone can produce an edge.
      prev_q <= act;
    end
  end

  assign act  = sync_q[SYNC_STAGES-1] ^ ~pol;
  assign rise = act & ~prev_q;

endmodule

// File: rtl/wb_irq_mux.sv
// rtl/wb_irq_mux.sv - Wishbone slave interrupt controller driving the mor1kx irq vector
//   Optional feature macro: WB_IRQ_MUX_SWTRIG_EN (maps SWSET at 0x14)
//   wb_clk_i, wb_rst_n_i         : clock, asynchronous active-low reset
//   wb_adr_i/dat_i/sel_i/we_i    : Wishbone request (adr[4:2] selects the register)
//   wb_cyc_i/stb_i/cti_i/bte_i   : Wishbone cycle control (cti/bte ignored)
//   wb_dat_o/ack_o/err_o/rty_o   : Wishbone response
//   irq_src_i                    : asynchronous interrupt sources
//   irq_o                        : interrupt vector, sources on [IRQ_BASE +: NUM_SRC]
module wb_irq_mux
  import wb_irq_mux_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int IRQ_BASE    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic [4:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic [2:0]         wb_cti_i,
  input  logic [1:0]         wb_bte_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic [31:0]        irq_o
);

  localparam bit CFG_OK = irq_cfg_ok(NUM_SRC, IRQ_BASE, SYNC_STAGES);

`ifdef WB_IRQ_MUX_SWTRIG_EN
  localparam bit SWTRIG = 1'b1;
`else
  localparam bit SWTRIG = 1'b0;
`endif

  localparam logic [2:0] IDX_STATUS   = IRQ_REG_STATUS[4:2];
  localparam logic [2:0] IDX_PENDING  = IRQ_REG_PENDING[4:2];
  localparam logic [2:0] IDX_MASK     = IRQ_REG_MASK[4:2];
  localparam logic [2:0] IDX_MODE     = IRQ_REG_MODE[4:2];
  localparam logic [2:0] IDX_POLARITY = IRQ_REG_POLARITY[4:2];
  localparam logic [2:0] IDX_SWSET    = IRQ_REG_SWSET[4:2];

  bus_state_e state_q, state_d;

  logic [NUM_SRC-1:0] mask_q, mode_q, pol_q, pend_q, irq_q;
  logic [NUM_SRC-1:0] act, rise, pend_d, clr, sw_set;
  logic [NUM_SRC-1:0] wr_bits, wr_lanes;
  logic [31:0]        lane_mask, wr_word, rdata, dat_q;
  logic [31:0]        irq_vec;
  logic [2:0]         reg_idx;
  logic               mapped, req, wr_en, rd_en;

  // ---------------------------------------------------------------- sources
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    wb_irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (wb_clk_i),
      .rst_n(wb_rst_n_i),
      .src  (irq_src_i[i]),
      .pol  (pol_q[i]),
      .act  (act[i]),
      .rise (rise[i])
    );
  end

  // ---------------------------------------------------------------- decode
  assign reg_idx = wb_adr_i[4:2];

  always_comb begin
    mapped = 1'b0;
    rdata  = '0;
    case (reg_idx)
      IDX_STATUS:   begin mapped = 1'b1; rdata[NUM_SRC-1:0] = act;    end
      IDX_PENDING:  begin mapped = 1'b1; rdata[NUM_SRC-1:0] = pend_q; end
      IDX_MASK:     begin mapped = 1'b1; rdata[NUM_SRC-1:0] = mask_q; end
      IDX_MODE:     begin mapped = 1'b1; rdata[NUM_SRC-1:0] = mode_q; end
      IDX_POLARITY: begin mapped = 1'b1; rdata[NUM_SRC-1:0] = pol_q;  end
      IDX_SWSET:    mapped = SWTRIG;  // write-only, reads 0
      default:      mapped = 1'b0;
    endcase
  end

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < 4; b++) lane_mask[8*b +: 8] = {8{wb_sel_i[b]}};
  end

  assign wr_word  = wb_dat_i & lane_mask;
  assign wr_bits  = wr_word[NUM_SRC-1:0];
  assign wr_lanes = lane_mask[NUM_SRC-1:0];

  // ---------------------------------------------------------------- bus FSM
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= BUS_IDLE;
    else             state_q <= state_d;
  end

  // A request is only taken from IDLE, so every beat costs two cycles and an
  // already-issued response completes even if the master drops cyc.
  always_comb begin
    state_d = BUS_IDLE;
    req     = 1'b0;
    if (state_q == BUS_IDLE && wb_cyc_i && wb_stb_i) begin
      req     = 1'b1;
      state_d = mapped ? BUS_ACK : BUS_ERR;
    end
  end

  assign wr_en = req & mapped & wb_we_i;
  assign rd_en = req & mapped & ~wb_we_i;

  // ---------------------------------------------------------------- pending
  assign clr = (wr_en && reg_idx == IDX_PENDING) ? wr_bits : '0;

`ifdef WB_IRQ_MUX_SWTRIG_EN
  assign sw_set = (wr_en && reg_idx == IDX_SWSET) ? wr_bits : '0;
`else
  assign sw_set = '0;
`endif

  // Edge bits: set (hardware or software) wins over a same-cycle W1C.
  // Level bits: follow the active level, W1C and SWSET have no effect.
  assign pend_d = (mode_q & (rise | sw_set | (pend_q & ~clr))) | (~mode_q & act);

  // ---------------------------------------------------------------- registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      mask_q <= '0;
      mode_q <= '0;
      pol_q  <= '0;
      pend_q <= '0;
      irq_q  <= '0;
      dat_q  <= IRQ_RST_DATA;
    end else begin
      if (wr_en && reg_idx == IDX_MASK)     mask_q <= (mask_q & ~wr_lanes) | wr_bits;
      if (wr_en && reg_idx == IDX_MODE)     mode_q <= (mode_q & ~wr_lanes) | wr_bits;
      if (wr_en && reg_idx == IDX_POLARITY) pol_q  <= (pol_q  & ~wr_lanes) | wr_bits;
      pend_q <= pend_d;
      irq_q  <= pend_q & mask_q;
      dat_q  <= rd_en ? rdata : IRQ_RST_DATA;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign wb_ack_o = (state_q == BUS_ACK);
  assign wb_err_o = (state_q == BUS_ERR);
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = dat_q;

  assign irq_vec = {{(IRQ_VEC_W-NUM_SRC){1'b0}}, irq_q} << IRQ_BASE;
  assign irq_o   = CFG_OK ? irq_vec : '0;

  logic unused_bits;
  assign unused_bits = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0], lane_mask, wr_word};

endmodule

// File: tb/tb_wb_irq_mux.sv
// tb/tb_wb_irq_mux.sv - self-checking bench for wb_irq_mux against a cycle model
module tb_wb_irq_mux;

  localparam int N    = 8;
  localparam int BASE = 2;
  localparam int S    = 2;

`ifdef WB_IRQ_MUX_SWTRIG_EN
  localparam bit SWT = 1'b1;
`else
  localparam bit SWT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  b_adr;
  logic [31:0] b_dat;
  logic [3:0]  b_sel;
  logic        b_we, b_cyc, b_stb;
  logic [2:0]  b_cti;
  logic [1:0]  b_bte;
  logic [N-1:0] src;
  logic [31:0] wb_dat_o, irq_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;

  always #5 clk = ~clk;

  wb_irq_mux #(.NUM_SRC(N), .IRQ_BASE(BASE), .SYNC_STAGES(S)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wb_adr_i(b_adr), .wb_dat_i(b_dat), .wb_sel_i(b_sel), .wb_we_i(b_we),
    .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_cti_i(b_cti), .wb_bte_i(b_bte),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .irq_src_i(src), .irq_o(irq_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what the spec says is visible after each clock edge.
  logic [N-1:0] m_mask, m_mode, m_pol, m_pend, m_irq, m_prev;
  logic [N-1:0] m_sq[$];          // sampled sources, newest first
  logic         m_ack, m_err;
  logic [31:0]  m_dat;
  logic [N-1:0] n_mask, n_mode, n_pol, n_pend, n_irq, n_prev, n_src;
  logic         n_ack, n_err;
  logic [31:0]  n_dat;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_mask = '0; m_mode = '0; m_pol = '0; m_pend = '0; m_irq = '0; m_prev = '0;
    m_ack = 1'b0; m_err = 1'b0; m_dat = '0;
    m_sq = {};
    repeat (S) m_sq.push_front('0);
  endtask

  function automatic logic [31:0] read_reg(input int idx, input logic [N-1:0] a);
    logic [31:0] r;
    r = '0;
    case (idx)
      0: r[N-1:0] = a;
      1: r[N-1:0] = m_pend;
      2: r[N-1:0] = m_mask;
      3: r[N-1:0] = m_mode;
      4: r[N-1:0] = m_pol;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_next();
    logic [N-1:0] act_now, rise, wbits, lanes, clr, sw;
    logic [31:0]  be, wword;
    logic         req, mapped, wr;
    int           idx;
    act_now = m_sq[S-1] ^ ~m_pol;
    rise    = act_now & ~m_prev;
    req     = b_cyc & b_stb & ~m_ack & ~m_err;
    idx     = int'(b_adr[4:2]);
    mapped  = (idx <= 4) || (idx == 5 && SWT);
    for (int b = 0; b < 4; b++) be[8*b +: 8] = {8{b_sel[b]}};
    wword = b_dat & be;
    wbits = wword[N-1:0];
    lanes = be[N-1:0];
    wr    = req && mapped && b_we;
    n_ack = req && mapped;
    n_err = req && !mapped;
    n_dat = (req && mapped && !b_we) ? read_reg(idx, act_now) : 32'h0;
    n_mask = (wr && idx == 2) ? ((m_mask & ~lanes) | wbits) : m_mask;
    n_mode = (wr && idx == 3) ? ((m_mode & ~lanes) | wbits) : m_mode;
    n_pol  = (wr && idx == 4) ? ((m_pol  & ~lanes) | wbits) : m_pol;
    clr = (wr && idx == 1) ? wbits : '0;
    sw  = (wr && idx == 5) ? wbits : '0;
    for (int i = 0; i < N; i++) begin
      if (m_mode[i]) n_pend[i] = rise[i] | sw[i] | (m_pend[i] & ~clr[i]);
      else           n_pend[i] = act_now[i];
    end
    n_irq  = m_pend & m_mask;
    n_prev = act_now;
    n_src  = src;
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_mask = n_mask; m_mode = n_mode; m_pol = n_pol; m_pend = n_pend;
      m_irq = n_irq; m_prev = n_prev; m_ack = n_ack; m_err = n_err; m_dat = n_dat;
      m_sq.push_front(n_src);
      void'(m_sq.pop_back());
    end
  endtask

  // One clock: compare at the falling edge, then advance DUT and model together.
  task automatic step();
    @(negedge clk);
    chk("irq_o", irq_o, 32'(m_irq) << BASE);
    chk("ack", 32'(wb_ack_o), 32'(m_ack));
    chk("err", 32'(wb_err_o), 32'(m_err));
    chk("dat_o", wb_dat_o, m_dat);
    chk("rty", 32'(wb_rty_o), 32'h0);
    model_next();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic bus(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic ak, output logic er);
    b_cyc = 1'b1; b_stb = 1'b1; b_we = we; b_adr = a; b_dat = d; b_sel = s;
    step();
    rd = wb_dat_o; ak = wb_ack_o; er = wb_err_o;
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
    step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] rd; logic ak, er;
    bus(1'b1, a, d, 4'hF, rd, ak, er);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] want);
    logic [31:0] rd; logic ak, er;
    bus(1'b0, a, 32'h0, 4'hF, rd, ak, er);
    chk(name, rd, want);
  endtask

  initial begin
    logic [31:0] rd;
    logic ak, er;
    rst_n = 1'b0; src = 8'hFF;
    b_cyc = 0; b_stb = 0; b_we = 0; b_adr = 0; b_dat = 0; b_sel = 0; b_cti = 0; b_bte = 0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_irq", irq_o, 32'h0);
    repeat (5) step();
    rd_chk("rst_status", 5'h00, 32'h0);
    rd_chk("rst_pending", 5'h04, 32'h0);
    rd_chk("rst_mask", 5'h08, 32'h0);
    rd_chk("rst_mode", 5'h0C, 32'h0);
    rd_chk("rst_pol", 5'h10, 32'h0);
    chk("rst_masked_irq", irq_o, 32'h0);
    src = 8'h00;

    // Level mode, source 0 active-high
    wr(5'h10, 32'hFF);
    wr(5'h08, 32'h01);
    repeat (4) step();
    src = 8'h01;
    repeat (3) step();
    chk("lvl_t3", 32'(irq_o[2]), 32'h0);
    step();
    chk("lvl_t4", 32'(irq_o[2]), 32'h1);
    wr(5'h04, 32'h01);
    repeat (2) step();
    chk("lvl_w1c_noeffect", 32'(irq_o[2]), 32'h1);
    src = 8'h00;
    repeat (3) step();
    chk("lvl_off_t3", 32'(irq_o[2]), 32'h1);
    step();
    chk("lvl_off_t4", 32'(irq_o[2]), 32'h0);

    // Edge mode, source 1
    wr(5'h0C, 32'h02);
    wr(5'h08, 32'h03);
    src = 8'h02;
    step();
    src = 8'h00;
    repeat (3) step();
    chk("edge_set", irq_o, 32'h8);
    repeat (10) step();
    chk("edge_hold", irq_o, 32'h8);
    wr(5'h04, 32'h02);
    chk("edge_w1c", irq_o, 32'h0);

    // Edge and W1C on the same clock: set wins
    src = 8'h02;
    repeat (2) step();
    b_cyc = 1; b_stb = 1; b_we = 1; b_adr = 5'h04; b_dat = 32'h02; b_sel = 4'hF;
    step();
    b_cyc = 0; b_stb = 0; b_we = 0;
    step();
    rd_chk("set_wins", 5'h04, 32'h02);

    // Byte lanes and error path
    bus(1'b1, 5'h08, 32'hFFFF_FFFF, 4'h1, rd, ak, er);
    rd_chk("mask_lanes", 5'h08, 32'hFF);
    bus(1'b0, 5'h1C, 32'h0, 4'hF, rd, ak, er);
    chk("err_hit", 32'(er), 32'h1);
    chk("err_noack", 32'(ak), 32'h0);
    chk("err_dat", rd, 32'h0);
    chk("err_1cyc", 32'(wb_err_o), 32'h0);

    // Software trigger
    wr(5'h0C, 32'h06);
    wr(5'h04, 32'hFF);
    rd_chk("sw_pre", 5'h04, 32'h0);
    bus(1'b1, 5'h14, 32'h04, 4'hF, rd, ak, er);
    chk("sw_ack", 32'(ak), 32'(SWT));
    chk("sw_err", 32'(er), 32'(!SWT));
    rd_chk("sw_pend", 5'h04, SWT ? 32'h04 : 32'h0);

    // Random traffic against the model, with one reset in mid-transaction
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) src[$urandom_range(0, N-1)] ^= 1'b1;
      b_cyc = ($urandom_range(0, 2) == 0);
      b_stb = b_cyc ? ($urandom_range(0, 4) != 0) : $urandom_range(0, 1) == 1;
      b_we  = $urandom_range(0, 1) == 1;
      b_adr = 5'($urandom_range(0, 31));
      b_dat = $urandom;
      b_sel = 4'($urandom_range(0, 15));
      b_cti = 3'($urandom_range(0, 7));
      b_bte = 2'($urandom_range(0, 3));
      step();
      if (i == 1500) begin
        rst_n = 1'b0;
        model_reset();
        chk("async_rst_ack", 32'(wb_ack_o | wb_err_o), 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
      end
    end
    b_cyc = 0; b_stb = 0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_irq_mux.md
# wb_irq_mux

Parametrised Wishbone B3 interrupt controller that collects up to 30 peripheral interrupt sources and drives the 32-bit mor1kx `irq_i` vector. It replaces the hard-wired zero assignments at the SoC top level. Each source has a synchronizer, a programmable level/edge mode, a programmable polarity, a pending latch and a mask. The block sits on the Wishbone interconnect as a slave, beside the UART and RAM slaves.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 1..30.
- `IRQ_BASE`, 2: first `irq_o` bit driven. `IRQ_BASE+NUM_SRC` must be ≤ 32. Bits 0/1 are reserved for non-maskable use.
- `SYNC_STAGES`, 2: synchronizer flops per source, 2..3.
- `wb_clk_i` in 1: single clock for all logic.
- `wb_rst_n_i` in 1: reset, asynchronous, active-low.
- `wb_adr_i` in 5: byte address; `[4:2]` selects the register.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte-lane enables for writes.
- `wb_we_i` in 1: write strobe.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_cti_i` in 3: cycle type; ignored.
- `wb_bte_i` in 2: burst type; ignored.
- `wb_dat_o` out 32: read data.
- `wb_ack_o` out 1: acknowledge.
- `wb_err_o` out 1: error on an unmapped address.
- `wb_rty_o` out 1: tied to 0.
- `irq_src_i` in NUM_SRC: asynchronous interrupt sources.
- `irq_o` out 32: interrupt vector to the CPU. Only `[IRQ_BASE +: NUM_SRC]` are driven; all other bits are 0.

## Operation
- Register map. Bits at or above NUM_SRC read as 0 and ignore writes.
  - 0x00 STATUS, RO: synchronized raw inputs after polarity correction.
  - 0x04 PENDING: W1C for edge sources.
  - 0x08 MASK, RW: 1 = enabled.
  - 0x0C MODE, RW: 1 = edge, 0 = level.
  - 0x10 POLARITY, RW: 1 = active-high/rising, 0 = active-low/falling.
  - 0x14 SWSET, WO: only present with the macro (see Configuration); reads 0.
- Reset values: all registers 0, synchronizers 0, `irq_o`=0, `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0.
- Active level per source: `act = sync ^ ~pol`.
- Level source: PENDING bit tracks `act` every cycle. W1C has no effect.
- Edge source:
  - PENDING sets when `act` goes 0→1 (the previous-sample flop is kept after the synchronizer).
  - PENDING clears on W1C.
  - If a set and a clear occur in the same cycle, set wins.
- Changing MODE or POLARITY takes effect on the next cycle. An edge caused purely by a polarity change is a valid edge.
- `irq_o[IRQ_BASE+i]` is the registered value of `PENDING[i] & MASK[i]`.
- Bus access:
  - A request is `cyc & stb & ~ack & ~err`.
  - For a mapped address, `wb_ack_o` pulses high one cycle later for exactly one cycle.
  - For an unmapped address (0x18–0x1C, and 0x14 without the macro), `wb_err_o` pulses instead and there is no write side effect.
  - Writes honour `wb_sel_i` per byte lane and commit on the clock edge that raises `ack`.
  - `wb_dat_o` is registered alongside `ack`, and is 0 whenever `ack` is low.
  - Bursts are served as single beats, each taking 2 cycles.
- If `cyc` drops mid-request, the already-registered ack still pulses once, and the master ignores it.
- Asserting reset mid-transaction clears everything immediately, including pending state.

## Timing
- Source edge to PENDING set: SYNC_STAGES+1 cycles.
- PENDING to `irq_o`: 1 cycle.
- Source edge to `irq_o`: SYNC_STAGES+2 cycles. With the default of 2 stages this is 4 cycles.
- Request to ack/err: 1 cycle.
- W1C commit to `irq_o` low: 1 cycle.
- MASK write to `irq_o` change: 1 cycle.
- Maximum throughput: one access every 2 cycles.

## Configuration
- `WB_IRQ_MUX_SWTRIG_EN` defined:
  - SWSET at 0x14 is mapped.
  - Writing 1 sets PENDING for edge-mode bits. This follows the same rule as a hardware edge, including set winning over a simultaneous W1C.
  - Bits for level-mode sources are ignored.
- Macro undefined:
  - 0x14 returns `wb_err_o`.
  - No software-trigger logic is generated.

## Structure
- Package `wb_irq_mux_pkg` holds the register offsets (`IRQ_REG_STATUS`…`IRQ_REG_SWSET`), reset constants, and the `NUM_SRC`/`IRQ_BASE` legality check constant.
- Sub-module `wb_irq_sync` is instantiated once per source. It contains the SYNC_STAGES synchronizer, the polarity XOR and the edge detector, and outputs `act` and `rise`.
- The top level contains the register file, the Wishbone FSM and the output register.

## Test plan
- Reset with `irq_src_i`=0xFF → `irq_o`=0 and all registers read 0; with MASK=0 no interrupt appears.
- Level mode: MASK=0x01, POL=0x01, `irq_src_i[0]` high at cycle T → `irq_o[2]`=1 at T+4. Source low → `irq_o[2]`=0 four cycles later. W1C to PENDING has no effect while the source is high.
- Edge mode: MODE=0x02, MASK=0x02, 1-cycle pulse on `irq_src_i[1]` → `irq_o[3]` stays 1. Writing 0x02 to PENDING → `irq_o[3]`=0 one cycle after ack.
- Simultaneous edge and W1C on source 1 in the same cycle → PENDING[1] stays 1.
- Byte lanes and error path: MASK write 0xFFFFFFFF with sel=0x1 and NUM_SRC=8 → reads back 0x000000FF. Read at 0x1C → `wb_err_o` pulses for one cycle and `wb_ack_o` stays 0.
- Software trigger: with `WB_IRQ_MUX_SWTRIG_EN`, write 0x04 to 0x14 in edge mode → PENDING=0x04. Without the macro, the same write → err and PENDING unchanged.
